// File: rtl/psum_in_bus_ctrl_if.sv
// psum_in_bus_ctrl_if: upstream push port, row broadcast bus and status of the psum input controller
interface psum_in_bus_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic                  ce;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] src_data;
  logic [ID_WIDTH-1:0]   src_id;
  logic                  src_valid;
  logic                  src_ready;
  logic [ID_WIDTH-1:0]   bus_source_id;
  logic [DATA_WIDTH-1:0] bus_data_out;
  logic                  bus_data_valid;
  logic                  pe_ready_any;
  logic                  timeout_err;
  logic                  busy;
  logic [CNT_W-1:0]      fifo_count;
  modport slave (
    input  ce, err_clr, src_data, src_id, src_valid, pe_ready_any,
    output src_ready, bus_source_id, bus_data_out, bus_data_valid, timeout_err, busy, fifo_count
  );
  modport master (
    output ce, err_clr, src_data, src_id, src_valid, pe_ready_any,
    input  src_ready, bus_source_id, bus_data_out, bus_data_valid, timeout_err, busy, fifo_count
  );
endinterface

// File: rtl/psum_in_bus_ctrl.sv
// psum_in_bus_ctrl: buffers tagged psums and broadcasts each one on the row bus once the addressed PE is ready
module psum_in_bus_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst_n,
  psum_in_bus_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t                         state_q;
  logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [AW:0]                    count_q;
  logic [CW-1:0]                  wait_q, wait_d;
  logic [ID_WIDTH+DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]            head_id;
  logic [DATA_WIDTH-1:0]          head_data;
  logic                           push, pop, set_err;
  assign {head_id, head_data} = mem_q[rd_ptr_q];
  assign bus.src_ready  = bus.ce && count_q != (AW+1)'(FIFO_DEPTH);
  assign bus.fifo_count = count_q;
  assign bus.busy       = count_q != '0 || state_q != IDLE;
  assign push    = bus.src_valid && bus.src_ready;
  // the head is consumed only when the addressed PE accepts it
  assign pop     = bus.ce && state_q == WAIT && bus.pe_ready_any;
  assign wait_d  = wait_q == CW'(TIMEOUT) ? wait_q : wait_q + 1'b1;
  assign set_err = bus.ce && state_q == WAIT && !bus.pe_ready_any && wait_d == CW'(TIMEOUT);
  // entry storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.src_id, bus.src_data};
  end
  // wrapping pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // broadcast FSM with registered bus outputs, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      wait_q             <= '0;
      bus.bus_source_id  <= '0;
      bus.bus_data_out   <= '0;
      bus.bus_data_valid <= 1'b0;
      bus.timeout_err    <= 1'b0;
    end else begin
      bus.timeout_err <= set_err ? 1'b1 : bus.err_clr ? 1'b0 : bus.timeout_err;
      if (bus.ce) begin
        case (state_q)
          IDLE: if (count_q != '0) begin
            bus.bus_source_id <= head_id;
            wait_q            <= '0;
            state_q           <= WAIT;
          end
          WAIT: if (bus.pe_ready_any) begin
            bus.bus_data_out   <= head_data;
            bus.bus_data_valid <= 1'b1;
            state_q            <= SEND;
          end else begin
            wait_q <= wait_d;
          end
          SEND: begin
            bus.bus_data_valid <= 1'b0;
            bus.bus_data_out   <= '0;
            if (count_q != '0) begin
              bus.bus_source_id <= head_id;
              wait_q            <= '0;
              state_q           <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
